// File: rtl/qc_ldpc_pkg.sv
// Shared types and helpers for the QC-LDPC parity accumulator.
// Block width is fixed at QC_MAX_Z and matches the top's default datapath width.
package qc_ldpc_pkg;

    localparam int QC_MAX_Z  = 81;
    localparam int QC_ZW     = 16;
    localparam int QC_MAX_NZ = 8;

    typedef enum logic [1:0] {
        ACC_ACCUM = 2'd0,
        ACC_SOLVE = 2'd1,
        ACC_HOLD  = 2'd2
    } acc_state_t;

    typedef logic [QC_MAX_Z-1:0] blk_t;
    typedef logic [QC_ZW-1:0]    zval_t;

    function automatic blk_t z_mask(input zval_t z);
        blk_t m;
        m = '0;
        for (int j = 0; j < QC_MAX_Z; j++) begin
            m[j] = (j < int'(z));
        end
        return m;
    endfunction

    // Lowest set bit wins; an all-zero select falls back to entry 0.
    function automatic zval_t z_from_onehot(
        input logic [QC_MAX_NZ-1:0]            req,
        input logic [QC_MAX_NZ-1:0][QC_ZW-1:0] tab
    );
        zval_t z;
        logic  found;
        z     = tab[0];
        found = 1'b0;
        for (int i = 0; i < QC_MAX_NZ; i++) begin
            if (!found && req[i]) begin
                z     = tab[i];
                found = 1'b1;
            end
        end
        return z;
    endfunction

    function automatic blk_t cyc_rot(
        input blk_t  x,
        input zval_t s,
        input zval_t z
    );
        blk_t  m;
        blk_t  xm;
        zval_t sm;
        m  = z_mask(z);
        xm = x & m;
        sm = (z == '0) ? '0 : (s % z);
        if (z == '0) begin
            return '0;
        end
        return ((xm << sm) | (xm >> (z - sm))) & m;
    endfunction

endpackage

// File: rtl/qc_ldpc_parity_accumulator_row_accum.sv
// One lambda register: masked XOR accumulate with synchronous clear.
// Clear has priority over accumulate.
module qc_ldpc_row_accum #(
    parameter int W = 81
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] din,
    input  logic [W-1:0] mask,
    output logic [W-1:0] lam
);

    logic [W-1:0] lam_q;
    logic [W-1:0] lam_d;

    always_comb begin
        lam_d = lam_q;
        if (clr) begin
            lam_d = '0;
        end else if (en) begin
            lam_d = lam_q ^ (din & mask);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lam_q <= '0;
        end else begin
            lam_q <= lam_d;
        end
    end

    assign lam = lam_q;

endmodule

// File: rtl/qc_ldpc_parity_accumulator.sv
// QC-LDPC lambda accumulation and dual-diagonal parity solve.
// Optional sticky overflow flag acc_err under QCLDPC_ACC_ERR_EN.
module qc_ldpc_parity_accumulator
    import qc_ldpc_pkg::*;
#(
    parameter int HIGHEST_SUPPORTED_Z_VAL      = 81,
    parameter int NUM_OF_SUPPORTED_Z           = 3,
    parameter int Z_VALUE_ARRAY [NUM_OF_SUPPORTED_Z] = '{27, 54, 81},
    parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
    parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4,
    parameter int P0_ROT                       = 1,
    parameter int MID_ROW                      = 1
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          rot_valid,
    input  logic [NUM_PARITY_BLKS_PER_CODE_BLK*HIGHEST_SUPPORTED_Z_VAL-1:0] rot_data,
    input  logic [NUM_OF_SUPPORTED_Z-1:0] req_z,
    output logic                          p_valid,
    output logic [NUM_PARITY_BLKS_PER_CODE_BLK*HIGHEST_SUPPORTED_Z_VAL-1:0] p_data,
    input  logic                          p_ready,
    output logic                          busy
`ifdef QCLDPC_ACC_ERR_EN
    ,
    output logic                          acc_err
`endif
);

    localparam int W  = HIGHEST_SUPPORTED_Z_VAL;
    localparam int NP = NUM_PARITY_BLKS_PER_CODE_BLK;
    localparam int NI = NUM_INFO_BLKS_PER_CODE_BLK;
    localparam int CW = $clog2(NI + 1);
    localparam int SW = $clog2(NP);

    acc_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          step_q, step_d;
    logic [QC_ZW-1:0]       z_q, z_d;
    logic [NP-1:0][W-1:0]   p_q, p_d;
    logic                   p_valid_q, p_valid_d;

    logic [QC_MAX_NZ-1:0][QC_ZW-1:0] z_tab;
    logic [QC_ZW-1:0]       beat_z;
    logic [W-1:0]           beat_mask;
    logic                   lam_en;
    logic                   lam_clr;
    logic [NP-1:0][W-1:0]   lam;
    logic [W-1:0]           lam_xor;
    logic [W-1:0]           p0_rot;
    logic [W-1:0]           step_val;

    for (genvar r = 0; r < NP; r++) begin : gen_rows
        qc_ldpc_row_accum #(
            .W(W)
        ) u_row (
            .CLK  (CLK),
            .rst_n(rst_n),
            .en   (lam_en),
            .clr  (lam_clr),
            .din  (rot_data[r*W +: W]),
            .mask (beat_mask),
            .lam  (lam[r])
        );
    end

    always_comb begin
        z_tab = '0;
        for (int i = 0; i < NUM_OF_SUPPORTED_Z; i++) begin
            z_tab[i] = QC_ZW'(Z_VALUE_ARRAY[i]);
        end
    end

    // The first beat must be masked with the Z it carries, not the stale one.
    assign beat_z    = (cnt_q == '0)
                     ? z_from_onehot(QC_MAX_NZ'(req_z), z_tab)
                     : z_q;
    assign beat_mask = z_mask(beat_z);
    assign p0_rot    = cyc_rot(p_q[0], QC_ZW'(P0_ROT), z_q);

    always_comb begin
        lam_xor = '0;
        for (int r = 0; r < NP; r++) begin
            lam_xor = lam_xor ^ lam[r];
        end
    end

    always_comb begin
        step_val = '0;
        if (step_q == '0) begin
            step_val = lam_xor;
        end else if (step_q == SW'(1)) begin
            step_val = lam[0] ^ p0_rot;
        end else begin
            for (int k = 2; k < NP; k++) begin
                if (int'(step_q) == k) begin
                    step_val = lam[k-1] ^ p_q[k-1]
                             ^ ((k - 1 == MID_ROW) ? p_q[0] : '0);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        z_d       = z_q;
        p_d       = p_q;
        p_valid_d = p_valid_q;
        lam_en    = 1'b0;
        lam_clr   = 1'b0;
        unique case (state_q)
            ACC_ACCUM: begin
                if (rot_valid) begin
                    lam_en = 1'b1;
                    if (cnt_q == '0) begin
                        z_d = beat_z;
                    end
                    if (cnt_q == CW'(NI - 1)) begin
                        cnt_d   = '0;
                        step_d  = '0;
                        state_d = ACC_SOLVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACC_SOLVE: begin
                p_d[step_q] = step_val;
                if (step_q == SW'(NP - 1)) begin
                    step_d    = '0;
                    lam_clr   = 1'b1;
                    p_valid_d = 1'b1;
                    state_d   = ACC_HOLD;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ACC_HOLD: begin
                if (p_ready) begin
                    p_valid_d = 1'b0;
                    state_d   = ACC_ACCUM;
                end
            end
            default: begin
                state_d = ACC_ACCUM;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC_ACCUM;
            cnt_q     <= '0;
            step_q    <= '0;
            z_q       <= QC_ZW'(Z_VALUE_ARRAY[0]);
            p_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            z_q       <= z_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
        end
    end

`ifdef QCLDPC_ACC_ERR_EN
    logic acc_err_q;
    logic acc_err_d;

    always_comb begin
        acc_err_d = acc_err_q;
        if (rot_valid && (state_q != ACC_ACCUM)) begin
            acc_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_err_q <= 1'b0;
        end else begin
            acc_err_q <= acc_err_d;
        end
    end

    assign acc_err = acc_err_q;
`endif

    assign p_valid = p_valid_q;
    assign p_data  = p_q;
    assign busy    = !((state_q == ACC_ACCUM) && (cnt_q == '0));

endmodule

// File: tb/tb_qc_ldpc_parity_accumulator.sv
// Directed self-checking bench for qc_ldpc_parity_accumulator.
// Build with QCLDPC_ACC_ERR_EN to also exercise acc_err.
module tb_qc_ldpc_parity_accumulator;

    localparam int W  = 81;
    localparam int NP = 4;
    localparam int NI = 20;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b1;
    logic              rot_valid = 1'b0;
    logic [NP*W-1:0]   rot_data = '0;
    logic [2:0]        req_z = 3'b001;
    logic              p_valid;
    logic [NP*W-1:0]   p_data;
    logic              p_ready = 1'b0;
    logic              busy;
`ifdef QCLDPC_ACC_ERR_EN
    logic              acc_err;
`endif

    int checks = 0;
    int errors = 0;

    qc_ldpc_parity_accumulator dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .rot_valid(rot_valid),
        .rot_data (rot_data),
        .req_z    (req_z),
        .p_valid  (p_valid),
        .p_data   (p_data),
        .p_ready  (p_ready),
        .busy     (busy)
`ifdef QCLDPC_ACC_ERR_EN
        ,
        .acc_err  (acc_err)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] bitv(input int n);
        logic [W-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [NP*W-1:0] pack4(
        input logic [W-1:0] a, input logic [W-1:0] b,
        input logic [W-1:0] c, input logic [W-1:0] d
    );
        return {d, c, b, a};
    endfunction

    function automatic logic [W-1:0] rot1(input logic [W-1:0] x, input int z);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < z; j++) r[(j + 1) % z] = x[j];
        return r;
    endfunction

    // Called on a negedge; each beat is sampled at the following posedge.
    task automatic send_cw(input logic [2:0] z, input int nbeats,
                           input int hot, input logic [NP*W-1:0] hot_data);
        for (int i = 0; i < nbeats; i++) begin
            rot_valid = 1'b1;
            req_z     = (i == 0) ? z : ~z;
            rot_data  = (i == hot) ? hot_data : '0;
            @(negedge CLK);
        end
        rot_valid = 1'b0;
        rot_data  = '0;
    endtask

    task automatic wait_valid(input bit inject, output int c);
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            if (inject && i == 1) begin
                rot_valid = 1'b1;
                rot_data  = '1;
            end
            @(negedge CLK);
            rot_valid = 1'b0;
            rot_data  = '0;
            if (p_valid === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic accept();
        p_ready = 1'b1;
        @(negedge CLK);
        p_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
        checks++; if (p_data !== '0) begin errors++; $display("FAIL reset_p_data: got %h want 0", p_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef QCLDPC_ACC_ERR_EN
        checks++; if (acc_err !== 1'b0) begin errors++; $display("FAIL reset_acc_err: got %b want 0", acc_err); end
`endif
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_zero_cw();
        int c;
        send_cw(3'b001, NI, -1, '0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_solve: got %b want 1", busy); end
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", c); end
        checks++; if (p_data !== '0) begin errors++; $display("FAIL zero_p_data: got %h want 0", p_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_hold: got %b want 1", busy); end
        accept();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL zero_p_valid_drop: got %b want 0", p_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_bit0_z27();
        int c;
        logic [NP*W-1:0] exp;
        logic [W-1:0] row3;
        exp = pack4(bitv(0), bitv(0) | bitv(1), bitv(1), bitv(1));
        send_cw(3'b001, NI, 0, pack4(bitv(0), '0, '0, '0));
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL bit0_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL bit0_p_data: got %h want %h", p_data, exp); end
        row3 = p_data[3*W +: W] ^ rot1(p_data[0 +: W], 27);
        checks++; if (row3 !== '0) begin errors++; $display("FAIL bit0_row3_eq: got %h want 0", row3); end
        accept();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL bit0_p_valid_drop: got %b want 0", p_valid); end
    endtask

    task automatic test_wrap_z81_hold();
        int c;
        logic [NP*W-1:0] exp;
        exp = pack4(bitv(80), bitv(0), bitv(0) | bitv(80), bitv(0));
        send_cw(3'b100, NI, 0, pack4('0, '0, bitv(80), '0));
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL wrap_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL wrap_p_data: got %h want %h", p_data, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL hold_p_valid[%0d]: got %b want 1", i, p_valid); end
            checks++; if (p_data !== exp) begin errors++; $display("FAIL hold_p_data[%0d]: got %h want %h", i, p_data, exp); end
        end
        accept();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", p_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_z_select();
        int c;
        logic [NP*W-1:0] exp;
        exp = pack4(bitv(0), bitv(1), bitv(1), bitv(1));
        send_cw(3'b000, NI, 3, pack4(bitv(30), bitv(0), '0, '0));
        wait_valid(1'b0, c);
        checks++; if (p_data !== exp) begin errors++; $display("FAIL zsel_zero_p_data: got %h want %h", p_data, exp); end
        accept();
        exp = pack4(bitv(53), bitv(53) | bitv(0), bitv(0), bitv(0));
        send_cw(3'b110, NI, 0, pack4(bitv(53) | bitv(60), '0, '0, '0));
        wait_valid(1'b0, c);
        checks++; if (p_data !== exp) begin errors++; $display("FAIL zsel_multi_p_data: got %h want %h", p_data, exp); end
        accept();
    endtask

    task automatic test_drop_in_solve();
        int c;
        logic [NP*W-1:0] exp;
        exp = pack4(bitv(0), bitv(0) | bitv(1), bitv(1), bitv(1));
        send_cw(3'b001, NI, 0, pack4(bitv(0), '0, '0, '0));
        wait_valid(1'b1, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL drop_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL drop_p_data: got %h want %h", p_data, exp); end
`ifdef QCLDPC_ACC_ERR_EN
        checks++; if (acc_err !== 1'b1) begin errors++; $display("FAIL drop_acc_err: got %b want 1", acc_err); end
`endif
        accept();
    endtask

    task automatic test_back_to_back();
        int c;
        logic [NP*W-1:0] exp;
        exp = pack4(bitv(10), bitv(11), bitv(11), bitv(11));
        send_cw(3'b010, NI, NI - 1, pack4('0, bitv(10), '0, '0));
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL b2b_first_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL b2b_first_p_data: got %h want %h", p_data, exp); end
        accept();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
        exp = pack4(bitv(0), bitv(0) | bitv(1), bitv(1), bitv(1));
        send_cw(3'b001, NI, 0, pack4(bitv(0), '0, '0, '0));
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL b2b_second_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL b2b_second_p_data: got %h want %h", p_data, exp); end
        accept();
    endtask

    task automatic test_reset_mid();
        int c;
        logic [NP*W-1:0] exp;
        send_cw(3'b001, 10, 2, pack4('0, '0, '0, bitv(5)));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL rmid_p_valid: got %b want 0", p_valid); end
        checks++; if (p_data !== '0) begin errors++; $display("FAIL rmid_p_data: got %h want 0", p_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
`ifdef QCLDPC_ACC_ERR_EN
        checks++; if (acc_err !== 1'b0) begin errors++; $display("FAIL rmid_acc_err: got %b want 0", acc_err); end
`endif
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        exp = pack4(bitv(0), bitv(0) | bitv(1), bitv(1), bitv(1));
        send_cw(3'b001, NI, 0, pack4(bitv(0), '0, '0, '0));
        wait_valid(1'b0, c);
        checks++; if (c !== 4) begin errors++; $display("FAIL rmid_fresh_latency: got %0d want 4", c); end
        checks++; if (p_data !== exp) begin errors++; $display("FAIL rmid_fresh_p_data: got %h want %h", p_data, exp); end
        accept();
    endtask

    initial begin
        test_reset();
        test_zero_cw();
        test_bit0_z27();
        test_wrap_z81_hold();
        test_z_select();
        test_drop_in_solve();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
